// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared FSM states, Set-2 scan-code constants and control ASCII values
package ps2_kbd_pkg;
  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
endpackage

// File: rtl/ps2_scan_to_ascii.sv
// ps2_scan_to_ascii: combinational Set-2 make code to ASCII lookup, 0 = unmapped
// PS2_KBD_EXT_KEYS_EN maps E0-prefixed navigation keys; otherwise extended codes return 0.
module ps2_scan_to_ascii
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] scan,
  input  logic       shift,
  input  logic       caps,
  input  logic       ext,
  output logic [7:0] ascii
);
  logic [7:0] lo, hi, base, ext_ascii;
  logic letter;
  always_comb begin
    lo = 8'h00;
    hi = 8'h00;
    case (scan)
      8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
      8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
      8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
      8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
      8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
      8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
      8'h35: lo = "y";  8'h1A: lo = "z";
      8'h45: {lo, hi} = {"0", ")"};  8'h16: {lo, hi} = {"1", "!"};
      8'h1E: {lo, hi} = {"2", "@"};  8'h26: {lo, hi} = {"3", "#"};
      8'h25: {lo, hi} = {"4", "$"};  8'h2E: {lo, hi} = {"5", "%"};
      8'h36: {lo, hi} = {"6", "^"};  8'h3D: {lo, hi} = {"7", "&"};
      8'h3E: {lo, hi} = {"8", "*"};  8'h46: {lo, hi} = {"9", "("};
      8'h4E: {lo, hi} = {"-", "_"};  8'h55: {lo, hi} = {"=", "+"};
      8'h54: {lo, hi} = {"[", "{"};  8'h5B: {lo, hi} = {"]", "}"};
      8'h5D: {lo, hi} = {"\\", "|"}; 8'h4C: {lo, hi} = {";", ":"};
      8'h52: {lo, hi} = {"'", "\""}; 8'h41: {lo, hi} = {",", "<"};
      8'h49: {lo, hi} = {".", ">"};  8'h4A: {lo, hi} = {"/", "?"};
      8'h0E: {lo, hi} = {8'h60, "~"};
      8'h29: {lo, hi} = {ASCII_SP, ASCII_SP};
      8'h5A: {lo, hi} = {ASCII_CR, ASCII_CR};
      8'h66: {lo, hi} = {ASCII_BS, ASCII_BS};
      8'h0D: {lo, hi} = {ASCII_TAB, ASCII_TAB};
      8'h76: {lo, hi} = {ASCII_ESC, ASCII_ESC};
      default: ;
    endcase
  end
  assign letter = (lo >= "a") && (lo <= "z");
  assign base = letter ? ((shift ^ caps) ? lo - 8'h20 : lo) : (shift ? hi : lo);
`ifdef PS2_KBD_EXT_KEYS_EN
  always_comb begin
    ext_ascii = 8'h00;
    case (scan)
      8'h75: ext_ascii = 8'h11;
      8'h72: ext_ascii = 8'h12;
      8'h6B: ext_ascii = 8'h13;
      8'h74: ext_ascii = 8'h14;
      8'h6C: ext_ascii = 8'h01;
      8'h69: ext_ascii = 8'h04;
      8'h71: ext_ascii = 8'h7F;
      8'h5A: ext_ascii = ASCII_CR;
      default: ;
    endcase
  end
`else
  assign ext_ascii = 8'h00;
`endif
  assign ascii = ext ? ext_ascii : base;
endmodule

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: PS/2 Set-2 scan-code decoder with shift/caps tracking and an ASCII FWFT FIFO
// Define PS2_KBD_EXT_KEYS_EN to queue arrow/navigation keys from E0-prefixed codes.
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       rd_en,
  output logic [7:0] ascii,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       shift_held,
  output logic       caps_on
);
  state_t state, state_nxt;
  logic lshift, rshift, is_prefix, is_mod, push, pop, wr;
  logic [7:0] lut;
  logic [7:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  assign shift_held = lshift | rshift;
  assign is_prefix = rx_data == SC_BREAK || rx_data == SC_EXT || rx_data == SC_PAUSE;
  assign is_mod = rx_data == SC_LSHIFT || rx_data == SC_RSHIFT || rx_data == SC_CAPS;
  ps2_scan_to_ascii u_lut (
    .scan (rx_data),
    .shift(shift_held),
    .caps (caps_on),
    .ext  (state == EXT),
    .ascii(lut)
  );
  always_comb begin
    state_nxt = state;
    if (rx_done_tick)
      case (state)
        IDLE:    state_nxt = rx_data == SC_BREAK ? BREAK : rx_data == SC_EXT ? EXT : IDLE;
        EXT:     state_nxt = rx_data == SC_BREAK ? EXT_BREAK : IDLE;
        default: state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_ff @(posedge clk)
    if (reset) begin
      lshift  <= 1'b0;
      rshift  <= 1'b0;
      caps_on <= 1'b0;
    end else if (rx_done_tick && state == IDLE) begin
      if (rx_data == SC_LSHIFT) lshift <= 1'b1;
      if (rx_data == SC_RSHIFT) rshift <= 1'b1;
      if (rx_data == SC_CAPS) caps_on <= ~caps_on;
    end else if (rx_done_tick && state == BREAK) begin
      if (rx_data == SC_LSHIFT) lshift <= 1'b0;
      if (rx_data == SC_RSHIFT) rshift <= 1'b0;
    end
  // A simultaneous pop frees the head slot, so a push while full still lands.
  assign push = rx_done_tick && lut != 8'h00 &&
                ((state == IDLE && !is_prefix && !is_mod) || (state == EXT && rx_data != SC_BREAK));
  assign pop = rd_en && !empty;
  assign wr = push && (!full || pop);
  assign empty = count == '0;
  assign full = count == (FIFO_AW+1)'(FIFO_DEPTH);
  assign ascii = empty ? 8'h00 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= lut;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);
      if (push && !wr) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// tb_ps2_kbd_decoder: directed self-checking bench for ps2_kbd_decoder
module tb_ps2_kbd_decoder;
  logic clk = 1'b0, reset = 1'b1, rx_done_tick = 1'b0, rd_en = 1'b0;
  logic [7:0] rx_data = 8'h00, ascii;
  logic empty, full, overflow, shift_held, caps_on;
  int checks = 0, errors = 0;
  ps2_kbd_decoder #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rd_en(rd_en), .ascii(ascii), .empty(empty), .full(full), .overflow(overflow),
    .shift_held(shift_held), .caps_on(caps_on)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask
  task automatic pop_exp(input string tag, input logic [7:0] exp);
    chk(tag, ascii, exp);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    logic [7:0] fill [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    do_reset();
    chk("rst_empty", 8'(empty), 8'h01);
    chk("rst_full", 8'(full), 8'h00);
    chk("rst_ascii", ascii, 8'h00);
    chk("rst_ovf", 8'(overflow), 8'h00);
    chk("rst_shift", 8'(shift_held), 8'h00);
    chk("rst_caps", 8'(caps_on), 8'h00);
    send(8'h1C);
    chk("a_empty", 8'(empty), 8'h00);
    chk("a_ascii", ascii, 8'h61);
    send(8'hF0); send(8'h1C);
    pop_exp("a_pop", 8'h61);
    chk("a_empty_after", 8'(empty), 8'h01);
    chk("a_ascii_after", ascii, 8'h00);
    @(negedge clk); rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    chk("pop_empty_noop", 8'(empty), 8'h01);
    send(8'h12);
    chk("shift_on", 8'(shift_held), 8'h01);
    send(8'h1C); send(8'hF0); send(8'h12);
    chk("shift_off", 8'(shift_held), 8'h00);
    send(8'h1C);
    pop_exp("shift_A", 8'h41);
    pop_exp("shift_a", 8'h61);
    send(8'h12); send(8'h58); send(8'hF0); send(8'h58);
    chk("caps_on", 8'(caps_on), 8'h01);
    send(8'h1C); send(8'h16);
    pop_exp("caps_shift_a", 8'h61);
    pop_exp("shift_bang", 8'h21);
    send(8'hF0); send(8'h12); send(8'h16); send(8'h1C);
    pop_exp("caps_digit", 8'h31);
    pop_exp("caps_A", 8'h41);
    send(8'h58);
    chk("caps_off", 8'(caps_on), 8'h00);
    send(8'h5A);
    pop_exp("enter", 8'h0D);
    send(8'h4E);
    pop_exp("minus", 8'h2D);
    for (int i = 0; i < 8; i++) send(fill[i]);
    chk("fill_full", 8'(full), 8'h01);
    chk("fill_ovf0", 8'(overflow), 8'h00);
    send(fill[8]);
    chk("ovf_set", 8'(overflow), 8'h01);
    chk("ovf_head", ascii, 8'h61);
    @(negedge clk);
    rd_en = 1'b1; rx_done_tick = 1'b1; rx_data = 8'h29;
    @(negedge clk);
    rd_en = 1'b0; rx_done_tick = 1'b0;
    chk("rw_full", 8'(full), 8'h01);
    pop_exp("drain_b", 8'h62);
    pop_exp("drain_c", 8'h63);
    pop_exp("drain_d", 8'h64);
    pop_exp("drain_e", 8'h65);
    pop_exp("drain_f", 8'h66);
    pop_exp("drain_g", 8'h67);
    pop_exp("drain_h", 8'h68);
    pop_exp("drain_sp", 8'h20);
    chk("drain_empty", 8'(empty), 8'h01);
    chk("ovf_sticky", 8'(overflow), 8'h01);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
`ifdef PS2_KBD_EXT_KEYS_EN
    pop_exp("ext_up", 8'h11);
`endif
    chk("ext_empty", 8'(empty), 8'h01);
    send(8'h1C);
    pop_exp("ext_idle", 8'h61);
    send(8'hF0);
    do_reset();
    chk("rst_ovf_clr", 8'(overflow), 8'h00);
    send(8'h1C);
    chk("rst_prefix", ascii, 8'h61);
    chk("rst_prefix_empty", 8'(empty), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_decoder.md
Name: ps2_kbd_decoder

Overview:
- Sits directly downstream of the PS/2 receiver; consumes its rx_done_tick / rx_data byte stream.
- Interprets Set-2 scan codes: F0 break prefix, E0 extended prefix, shift and caps-lock state.
- Converts make codes to ASCII and queues characters in a small first-word-fall-through FIFO.
- The CPU-side keyboard port pops characters from the FIFO.

Parameters:
- FIFO_DEPTH, 8, number of ASCII entries (power of two, 2..64).
- FIFO_AW, 3, address width; must equal log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  one-cycle strobe: rx_data is valid.
- rx_data  in  8  received scan-code byte.
- rd_en  in  1  pop the head entry; ignored when empty.
- ascii  out  8  head-of-FIFO character; 0x00 when empty.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- overflow  out  1  sticky; set when a character is dropped because the FIFO is full.
- shift_held  out  1  either shift key is currently down.
- caps_on  out  1  caps-lock toggle state.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: FSM = IDLE, FIFO empty (empty=1, full=0, ascii=0x00), overflow=0, lshift=rshift=0, caps_on=0.
- Reset asserted mid-sequence (for example after F0) discards the pending prefix.
- Bytes are processed only in cycles where rx_done_tick=1. All other cycles leave the FSM unchanged.
- FSM states and transitions on each received byte b:
  - IDLE: b=F0 -> BREAK; b=E0 -> EXT; b=E1 -> IDLE (ignored); otherwise make(b) -> IDLE.
  - BREAK: 12 clears lshift, 59 clears rshift; any other byte is ignored. Next state IDLE.
  - EXT: b=F0 -> EXT_BREAK; otherwise ext_make(b) -> IDLE.
  - EXT_BREAK: byte ignored -> IDLE.
- make(b) actions:
  - 12 sets lshift; 59 sets rshift.
  - 58 toggles caps_on.
  - Otherwise b is looked up in the ASCII table. A non-zero result is pushed; a zero result is discarded.
- ext_make(b): discarded unless the optional feature is enabled.
- Shift and caps rules:
  - Letters: uppercase when shift_held XOR caps_on.
  - Digits and symbols: shifted glyph only when shift_held.
  - Typematic repeats (the same make code repeated) push again each time.
- Minimum ASCII table:
  - Letters a-z: 1C=a, 32=b, ... 1A=z.
  - Digits 0-9: 45=0, 16=1, ... 46=9, with shifted glyphs ) ! @ # $ % ^ & *.
  - Punctuation: - = [ ] \ ; ' , . / ` and their shifted forms.
  - Controls: 29=0x20 (space), 5A=0x0D (Enter), 66=0x08 (Backspace), 0D=0x09 (Tab), 76=0x1B (Esc).
- Latency: a tick at edge N for a mapped make code gives empty=0 and valid ascii after edge N (one registered cycle).
- FIFO rules:
  - Push while full (and no rd_en in the same cycle): the character is dropped, overflow is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle: both succeed, and the count is unchanged. This holds even when full.
  - rd_en while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH; full and empty are derived from an FIFO_AW+1-bit count.
- overflow clears only on reset.

Optional Feature:
- Macro: PS2_KBD_EXT_KEYS_EN.
- Defined: ext_make pushes arrow and navigation keys:
  - E0 75 (up) -> 0x11, E0 72 (down) -> 0x12, E0 6B (left) -> 0x13, E0 74 (right) -> 0x14.
  - E0 6C (home) -> 0x01, E0 69 (end) -> 0x04, E0 71 (delete) -> 0x7F.
  - E0 5A (keypad Enter) -> 0x0D.
  - These codes ignore shift and caps.
- Undefined: all extended make codes are consumed and discarded. The FSM sequence is identical in both builds.

Decomposition:
- Package ps2_kbd_pkg holds:
  - FSM state encoding constants (IDLE, BREAK, EXT, EXT_BREAK).
  - Prefix constants SC_BREAK=F0, SC_EXT=E0, SC_PAUSE=E1.
  - Key constants SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58.
  - Control ASCII constants.
- Sub-module ps2_scan_to_ascii: a purely combinational lookup with inputs scan[7:0], shift, caps, ext and output ascii[7:0], where 0 means unmapped. The FSM and FIFO stay in the top module.

Test Plan:
- Reset, then ticks 1C, F0 1C -> one entry ascii=0x61, empty=0; rd_en pulse -> empty=1, ascii=0x00.
- Ticks 12, 1C, F0 12, 1C -> FIFO pops 0x41 then 0x61; shift_held=1 only between 12 and F0 12.
- Ticks 58, F0 58, 1C, 16 with 12 held -> caps_on=1; pops 0x61 (shift XOR caps) then 0x21 ('!').
- Push 9 mapped codes with FIFO_DEPTH=8 and no reads -> full=1, overflow=1, first 8 characters intact in order. Then rd_en and a tick on the same cycle -> count remains 8.
- E0 75, E0 F0 75 -> 0x11 pushed with PS2_KBD_EXT_KEYS_EN defined; nothing pushed without it; FSM returns to IDLE in both builds.
- Ticks F0 then reset, then 1C -> 0x61 pushed; the break prefix is lost.
